// File: rtl/bram_if_pkg.sv
// Shared FSM encoding and arbitration mode constants for the BRAM arbiter.
package bram_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from last+1, or fixed priority with ch0 highest.
module rr_arbiter
  import bram_if_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned j;
      j = mode ? k : (32'(last) + 32'd1 + k) % NUM_CH;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bram_arb_if.sv
// Multi-channel BRAM port arbiter: one transfer at a time through IDLE/ACCESS/WAIT,
// per-channel done pulses and held read data.
module bram_arb_if
  import bram_if_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                       axi_clk,
  input  logic                       axi_rst,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_be,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_gnt,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic                       clk_BRAM,
  output logic                       rst_BRAM,
  output logic [ADDR_W-1:0]          addr_BRAM,
  output logic [DATA_W-1:0]          dout_BRAM,
  input  logic [DATA_W-1:0]          din_BRAM,
  output logic                       en_BRAM,
  output logic [DATA_W/8-1:0]        we_BRAM
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_winner;
  logic [IDX_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic [1:0]        wait_cnt;
  logic              we_r;
  logic [BE_W-1:0]   be_r;
  logic              xfer;
  logic              last_wait;

  assign clk_BRAM = axi_clk;
  assign rst_BRAM = axi_rst;

  rr_arbiter #(
    .NUM_CH(NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (ch_req),
    .last(last_winner),
    .mode(PRIO_MODE == PRIO_FIXED),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grant is gated by reset so ch_gnt reads zero while reset holds state in IDLE.
  always_comb begin
    state_nxt = state;
    ch_gnt    = '0;
    xfer      = 1'b0;
    en_BRAM   = 1'b0;
    we_BRAM   = '0;
    last_wait = 1'b0;
    case (state)
      IDLE: begin
        if (!axi_rst && (|ch_req)) begin
          ch_gnt    = arb_gnt;
          xfer      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        en_BRAM   = 1'b1;
        we_BRAM   = we_r ? be_r : '0;
        state_nxt = we_r ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'd0) begin
          last_wait = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACCESS && !we_r)
        wait_cnt <= 2'(RD_LAT - 1);
      else if (state == WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // last_winner doubles as the in-flight owner: it only moves on a transfer.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      last_winner <= IDX_W'(NUM_CH - 1);
      we_r        <= 1'b0;
      be_r        <= '0;
      addr_BRAM   <= '0;
      dout_BRAM   <= '0;
      ch_done     <= '0;
      ch_rdata    <= '0;
    end else begin
      ch_done <= '0;
      if (xfer) begin
        last_winner <= arb_idx;
        we_r        <= ch_we[arb_idx];
        be_r        <= ch_be[arb_idx*BE_W +: BE_W];
        addr_BRAM   <= ch_addr[arb_idx*ADDR_W +: ADDR_W];
        dout_BRAM   <= ch_wdata[arb_idx*DATA_W +: DATA_W];
      end
      if (state == ACCESS && we_r)
        ch_done[last_winner] <= 1'b1;
      if (last_wait) begin
        ch_done[last_winner]                    <= 1'b1;
        ch_rdata[last_winner*DATA_W +: DATA_W] <= din_BRAM;
      end
    end
  end

endmodule

// File: tb/tb_bram_arb_if.sv
// Directed bench: 4-ch round-robin RD_LAT=1 instance with a BRAM model, and a
// 2-ch fixed-priority RD_LAT=3 instance with hand-driven read data.
module tb_bram_arb_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Instance A: NUM_CH=4, round-robin, RD_LAT=1
  logic         rst_a;
  logic [3:0]   a_req, a_we, a_gnt, a_done, a_web;
  logic [15:0]  a_be;
  logic [127:0] a_addr, a_wdata, a_rdata;
  logic         a_clkb, a_rstb, a_en;
  logic [31:0]  a_addrb, a_doutb, a_din;

  bram_arb_if #(.NUM_CH(4), .DATA_W(32), .ADDR_W(32), .RD_LAT(1), .PRIO_MODE(0)) dut_a (
    .axi_clk(clk), .axi_rst(rst_a), .ch_req(a_req), .ch_we(a_we), .ch_be(a_be),
    .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_gnt(a_gnt), .ch_done(a_done),
    .ch_rdata(a_rdata), .clk_BRAM(a_clkb), .rst_BRAM(a_rstb), .addr_BRAM(a_addrb),
    .dout_BRAM(a_doutb), .din_BRAM(a_din), .en_BRAM(a_en), .we_BRAM(a_web)
  );

  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  initial a_din = '0;
  always @(posedge clk) begin
    if (a_en) begin
      for (int b = 0; b < 4; b++)
        if (a_web[b]) mem[a_addrb[7:0]][b*8 +: 8] <= a_doutb[b*8 +: 8];
      a_din <= mem[a_addrb[7:0]];
    end
  end

  // Instance B: NUM_CH=2, fixed priority, RD_LAT=3
  logic        rst_b;
  logic [1:0]  b_req, b_we, b_gnt, b_done;
  logic [7:0]  b_be;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic        b_clkb, b_rstb, b_en;
  logic [31:0] b_addrb, b_doutb, b_din;
  logic [3:0]  b_web;

  bram_arb_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RD_LAT(3), .PRIO_MODE(1)) dut_b (
    .axi_clk(clk), .axi_rst(rst_b), .ch_req(b_req), .ch_we(b_we), .ch_be(b_be),
    .ch_addr(b_addr), .ch_wdata(b_wdata), .ch_gnt(b_gnt), .ch_done(b_done),
    .ch_rdata(b_rdata), .clk_BRAM(b_clkb), .rst_BRAM(b_rstb), .addr_BRAM(b_addrb),
    .dout_BRAM(b_doutb), .din_BRAM(b_din), .en_BRAM(b_en), .we_BRAM(b_web)
  );

  // One full transfer on instance A; returns in the done cycle so the next call
  // can be granted in that same cycle.
  task automatic a_xfer(input int ch, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    int lat;
    bit seen;
    a_req            = 4'(1 << ch);
    a_we[ch]         = we;
    a_addr[ch*32 +: 32]  = addr;
    a_wdata[ch*32 +: 32] = data;
    a_be[ch*4 +: 4]      = be;
    #1 check("a_gnt", 64'(a_gnt), 64'(1 << ch));
    nxt();
    a_req = '0;
    #1;
    check("a_en_access", 64'(a_en), 64'd1);
    check("a_we_bram", 64'(a_web), we ? 64'(be) : 64'd0);
    check("a_addr_bram", 64'(a_addrb), 64'(addr));
    check("a_gnt_access", 64'(a_gnt), 64'd0);
    if (we) check("a_dout_bram", 64'(a_doutb), 64'(data));
    lat  = 1;
    seen = 0;
    while (!seen && lat < 8) begin
      nxt();
      lat++;
      #1;
      if (a_done != 4'd0) seen = 1;
    end
    check("a_done", 64'(a_done), 64'(1 << ch));
    check("a_latency", 64'(lat), we ? 64'd2 : 64'd3);
  endtask

  int done_cnt [4];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_req = 4'b0001; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0; b_din = '0;
    #3;
    check("rst_gnt", 64'(a_gnt), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_rdata", 64'(|a_rdata), 64'd0);
    check("rst_en", 64'(a_en), 64'd0);
    check("rst_we", 64'(a_web), 64'd0);
    check("rst_addr", 64'(a_addrb), 64'd0);
    check("rst_dout", 64'(a_doutb), 64'd0);
    check("rst_bram", 64'(a_rstb), 64'd1);
    check("clk_bram", 64'(a_clkb), 64'(clk));
    nxt();
    nxt();
    a_req = '0; rst_a = 1'b0; rst_b = 1'b0;
    #1 check("rst_bram_rel", 64'(b_rstb), 64'd0);

    // write then read, and byte-enable merge with back-to-back grants
    a_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    a_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    check("rd_ch0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    a_xfer(2, 1'b1, 32'h20, 32'h11223344, 4'hF);
    a_xfer(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'h3);
    check("wr_keeps_rdata0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    check("wr_keeps_rdata2", 64'(a_rdata[95:64]), 64'h0);
    a_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0);
    check("rd_be_merge", 64'(a_rdata[95:64]), 64'h1122CCDD);

    // request dropped before grant produces no done
    nxt();
    a_req = 4'b0010; a_we[1] = 1'b1; a_addr[63:32] = 32'h30; a_wdata[63:32] = 32'h5; a_be[7:4] = 4'hF;
    #1 check("drop_gnt1", 64'(a_gnt), 64'b0010);
    nxt();
    a_req = 4'b1000; a_we[3] = 1'b1;
    #1 check("drop_gnt_busy", 64'(a_gnt), 64'd0);
    nxt();
    a_req = '0;
    #1 check("drop_done1", 64'(a_done), 64'b0010);
    nxt();
    #1 check("drop_no_done", 64'(a_done), 64'd0);
    nxt();
    #1 check("drop_no_done2", 64'(a_done), 64'd0);

    // round-robin from a fresh reset with all channels requesting
    rst_a = 1'b1;
    #1 rst_a = 1'b0;
    a_we = 4'hF; a_be = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin
      a_addr[c*32 +: 32]  = 32'h40 + 32'(c);
      a_wdata[c*32 +: 32] = 32'hC0 + 32'(c);
      done_cnt[c] = 0;
    end
    a_req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_gnt", 64'(a_gnt), 64'(1 << (g % 4)));
      if (g > 0) begin
        check("rr_done", 64'(a_done), 64'(1 << ((g - 1) % 4)));
        for (int c = 0; c < 4; c++) if (a_done[c]) done_cnt[c]++;
      end
      nxt();
      #1 check("rr_gnt_access", 64'(a_gnt), 64'd0);
      nxt();
    end
    a_req = '0;
    #1 check("rr_done_last", 64'(a_done), 64'b0001);
    for (int c = 0; c < 4; c++) check("rr_done_count", 64'(done_cnt[c]), 64'd1);

    // async reset during WAIT aborts the read
    nxt();
    a_req = 4'b0001; a_we[0] = 1'b0; a_addr[31:0] = 32'h10;
    nxt();
    a_req = '0;
    nxt();
    rst_a = 1'b1;
    a_req = 4'b0010;
    #1;
    check("wrst_en", 64'(a_en), 64'd0);
    check("wrst_done", 64'(a_done), 64'd0);
    check("wrst_gnt", 64'(a_gnt), 64'd0);
    check("wrst_rdata", 64'(|a_rdata), 64'd0);
    check("wrst_addr", 64'(a_addrb), 64'd0);
    check("wrst_dout", 64'(a_doutb), 64'd0);
    nxt();
    #1 check("wrst_done2", 64'(a_done), 64'd0);
    nxt();
    rst_a = 1'b0;
    #1 check("wrst_regrant", 64'(a_gnt), 64'b0010);
    nxt();
    a_req = '0;
    #1 check("wrst_done3", 64'(a_done), 64'd0);
    nxt();
    #1 check("wrst_done_ch1", 64'(a_done), 64'b0010);

    // fixed priority: ch1 starved while ch0 holds its request
    nxt();
    b_we = 2'b11; b_be = 8'hFF; b_addr = {32'h8, 32'h4}; b_wdata = {32'h22, 32'h11};
    b_req = 2'b11;
    for (int g = 0; g < 3; g++) begin
      #1;
      check("fp_gnt", 64'(b_gnt), 64'b01);
      if (g > 0) check("fp_done", 64'(b_done), 64'b01);
      nxt();
      #1 check("fp_gnt_access", 64'(b_gnt), 64'd0);
      nxt();
    end
    b_req = 2'b10;
    #1;
    check("fp_gnt_ch1", 64'(b_gnt), 64'b10);
    check("fp_done_last0", 64'(b_done), 64'b01);
    nxt();
    b_req = '0;
    nxt();
    #1 check("fp_done_ch1", 64'(b_done), 64'b10);

    // RD_LAT=3 read: capture din from the last WAIT cycle
    b_req = 2'b10; b_we = 2'b00; b_addr[63:32] = 32'h30; b_din = 32'h11110000;
    #1 check("l3_gnt", 64'(b_gnt), 64'b10);
    nxt();
    b_req = '0; b_din = 32'h11110001;
    #1;
    check("l3_en", 64'(b_en), 64'd1);
    check("l3_we", 64'(b_web), 64'd0);
    check("l3_addr", 64'(b_addrb), 64'h30);
    nxt();
    b_din = 32'h11110002;
    #1 check("l3_en_wait", 64'(b_en), 64'd0);
    nxt();
    b_din = 32'h11110003;
    nxt();
    b_din = 32'h5A5A0004;
    #1 check("l3_no_done_t4", 64'(b_done), 64'd0);
    nxt();
    b_din = 32'h11110005;
    #1;
    check("l3_done", 64'(b_done), 64'b10);
    check("l3_rdata", 64'(b_rdata[63:32]), 64'h5A5A0004);
    check("l3_rdata_ch0", 64'(b_rdata[31:0]), 64'h0);
    check("l3_dout", 64'(b_doutb), 64'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bram_arb_if.md
BRAM_ARB_IF -- requirements
Module: bram_arb_if

Interface
REQ-001 Parameters SHALL be as follows.
- NUM_CH, default 2: requester channel count, range 2..8.
- DATA_W, default 32: data width, a multiple of 8.
- ADDR_W, default 32: BRAM address width.
- RD_LAT, default 1: BRAM read latency in cycles, range 1..3.
- PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority (ch0 highest).

REQ-002 Ports SHALL be as follows.
- axi_clk, in, 1: the single clock.
- axi_rst, in, 1: reset, asynchronous, active-high.
- ch_req, in, NUM_CH: per-channel request, level.
- ch_we, in, NUM_CH: 1 = write, 0 = read.
- ch_be, in, NUM_CH*DATA_W/8: write byte enables.
- ch_addr, in, NUM_CH*ADDR_W: request address.
- ch_wdata, in, NUM_CH*DATA_W: write data.
- ch_gnt, out, NUM_CH: one-hot accept.
- ch_done, out, NUM_CH: one-cycle completion pulse.
- ch_rdata, out, NUM_CH*DATA_W: per-channel read data, held until that channel's next read.
- clk_BRAM, out, 1: equals axi_clk.
- rst_BRAM, out, 1: equals axi_rst.
- addr_BRAM, out, ADDR_W: BRAM address.
- dout_BRAM, out, DATA_W: drives BRAM DIN.
- din_BRAM, in, DATA_W: BRAM DOUT.
- en_BRAM, out, 1: BRAM enable.
- we_BRAM, out, DATA_W/8: BRAM byte write enables.

Function
REQ-003 All sequential logic SHALL use the rising edge of axi_clk only.
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS and WAIT.
REQ-005 In IDLE with any ch_req high, ch_gnt SHALL combinationally assert exactly one bit for the arbitration winner; a transfer occurs on a cycle where ch_req[i] and ch_gnt[i] are both high.
REQ-006 ch_gnt SHALL be all-zero outside IDLE.
REQ-007 A requester SHALL hold its fields stable while ch_req is high and un-granted; it may change them on the cycle after the transfer.
REQ-008 On a transfer at cycle T, the block SHALL register the winner's addr, wdata, be and we, and record the winner index; the state becomes ACCESS at T+1.
REQ-009 In ACCESS, en_BRAM SHALL be 1 for exactly one cycle, we_BRAM SHALL equal the registered be for a write and 0 for a read, and dout_BRAM and addr_BRAM SHALL carry the registered values.
REQ-010 Write: from ACCESS the FSM SHALL go to IDLE, with ch_done[winner] high at T+2; ch_rdata SHALL be unchanged.
REQ-011 Read: from ACCESS the FSM SHALL go to WAIT for RD_LAT cycles, counted by a down-counter.
REQ-012 On the last WAIT cycle, din_BRAM SHALL be captured into ch_rdata[winner]; ch_done[winner] SHALL be high at T+2+RD_LAT and the state SHALL be IDLE at that cycle.
REQ-013 en_BRAM SHALL be 0 and we_BRAM SHALL be 0 in IDLE and WAIT; addr_BRAM and dout_BRAM SHALL hold their last values.
REQ-014 A new grant may occur in the same cycle that ch_done is high; back-to-back writes from one channel SHALL therefore complete every 2 cycles.
REQ-015 Round-robin mode: the search SHALL start at (last_winner+1) mod NUM_CH; last_winner SHALL update only on a transfer.
REQ-016 Fixed-priority mode: the lowest-index requesting channel SHALL win.
REQ-017 A ch_req deasserted before grant SHALL be dropped silently, with no done pulse.
REQ-018 Simultaneous requests from all channels SHALL each be served exactly once per NUM_CH grants in round-robin mode.
REQ-019 ch_done SHALL be at most one-hot at any time.

Reset
REQ-020 While axi_rst is high, the following SHALL hold asynchronously:
- state = IDLE
- last_winner = NUM_CH-1 (so ch0 wins first)
- wait counter = 0
- ch_gnt = 0, ch_done = 0, ch_rdata = 0
- addr_BRAM = 0, dout_BRAM = 0, en_BRAM = 0, we_BRAM = 0

REQ-021 Reset asserted mid-transaction SHALL abort it with no done pulse; after release, pending requests SHALL re-arbitrate from ch0.

Structure
REQ-022 Package bram_if_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, WAIT=2) and the PRIO_MODE constants.
REQ-023 Arbitration SHALL live in sub-module rr_arbiter: inputs request vector, last_winner and mode; outputs one-hot grant and index; purely combinational.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Write then read, RD_LAT=1: ch0 writes addr 0x10, data 0xDEADBEEF, be 0xF at T -> we_BRAM=0xF, en=1 at T+1; ch0_done at T+2. Read of 0x10 -> ch0_rdata=0xDEADBEEF with done at T+3.
- Byte enables: write 0x11223344 then 0xAABBCCDD with be=0x3 to the same addr -> read returns 0x1122CCDD.
- Round-robin with NUM_CH=4, all ch_req held high -> grant order 0,1,2,3,0; each channel gets exactly one done per 4 grants.
- Fixed priority, ch0 and ch1 both held high -> ch1 is never granted until ch0 drops.
- RD_LAT=3 read -> en pulse at T+1, done at T+5, rdata matches din_BRAM sampled at T+4.
- Async reset asserted in WAIT -> all outputs 0 immediately with no done; after release, a ch1-only request is granted in the first IDLE cycle.
